// File: rtl/knight_link_pkg.sv
// Shared types and constants for the knight-side command link.
// Holds link defaults, the ack code and the FSM state enums.
package knight_link_pkg;

   localparam logic [7:0] POS_ACK = 8'hA5;
   localparam int DEF_BAUD_DIV = 2604;
   localparam int DEF_TIMEOUT_BITS = 40;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   typedef enum logic {
      WAIT_HI,
      WAIT_LO
   } pair_state_t;

   typedef enum logic {
      TX_IDLE,
      TX_XMIT
   } tx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: RX synchronizer, mid-bit sampling FSM.
// Emits one-cycle byte_rdy / frm_err pulses a clock after the stop sample.
module uart_rx_byte
   import knight_link_pkg::*;
#(
   parameter int BAUD_DIV = DEF_BAUD_DIV
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       byte_rdy,
   output logic       frm_err
);

   localparam int CW = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);

   rx_state_t state, state_nx;
   logic s1, s2, prev;
   logic [CW-1:0] cnt;
   logic [2:0] bit_cnt;
   logic brk;
   logic stop_hit, stop_val;
   logic tick;

   always_comb tick = (state == RX_START) ? (cnt == HALF) : (cnt == FULL);

   always_comb begin
      state_nx = state;
      unique case (state)
         RX_IDLE:  if (prev && !s2) state_nx = RX_START;
         RX_START: if (tick) state_nx = s2 ? RX_IDLE : RX_DATA;
         RX_DATA:  if (tick && bit_cnt == 3'd7) state_nx = RX_STOP;
         RX_STOP: begin
            // after a bad stop bit, hold until the line returns high
            if (brk) begin
               if (s2) state_nx = RX_IDLE;
            end else if (tick && s2) begin
               state_nx = RX_IDLE;
            end
         end
         default:  state_nx = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RX_IDLE;
         s1       <= 1'b1;
         s2       <= 1'b1;
         prev     <= 1'b1;
         cnt      <= '0;
         bit_cnt  <= '0;
         brk      <= 1'b0;
         stop_hit <= 1'b0;
         stop_val <= 1'b0;
         rx_byte  <= '0;
         byte_rdy <= 1'b0;
         frm_err  <= 1'b0;
      end else begin
         state    <= state_nx;
         s1       <= rx;
         s2       <= s1;
         prev     <= s2;
         byte_rdy <= stop_hit & stop_val;
         frm_err  <= stop_hit & ~stop_val;
         stop_hit <= 1'b0;
         unique case (state)
            RX_IDLE: begin
               cnt     <= CW'(1);
               bit_cnt <= '0;
               brk     <= 1'b0;
            end
            RX_START: cnt <= tick ? '0 : cnt + CW'(1);
            RX_DATA: begin
               cnt <= tick ? '0 : cnt + CW'(1);
               if (tick) begin
                  rx_byte <= {s2, rx_byte[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
               end
            end
            RX_STOP: begin
               cnt <= tick ? '0 : cnt + CW'(1);
               if (tick && !brk) begin
                  stop_hit <= 1'b1;
                  stop_val <= s2;
                  brk      <= ~s2;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/knight_cmd_link.sv
// Knight-side command link: pairs received bytes into 16-bit commands
// and serialises 8-bit responses back over TX.
module knight_cmd_link
   import knight_link_pkg::*;
#(
   parameter int BAUD_DIV     = DEF_BAUD_DIV,
   parameter int TIMEOUT_BITS = DEF_TIMEOUT_BITS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RX,
   output logic        TX,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic [7:0]  resp,
   input  logic        send_resp,
   output logic        tx_busy,
   output logic        resp_sent,
   output logic        frm_err
);

   localparam int TO_LIM = TIMEOUT_BITS * BAUD_DIV;
   localparam int TW = $clog2(TO_LIM + 1);
   localparam int BW = $clog2(BAUD_DIV);
   localparam logic [TW-1:0] TO_END = TW'(TO_LIM);
   localparam logic [BW-1:0] BIT_END = BW'(BAUD_DIV - 1);

   logic [7:0] rx_byte;
   logic byte_rdy;

   uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
      .clk      (clk),
      .rst      (rst),
      .rx       (RX),
      .rx_byte  (rx_byte),
      .byte_rdy (byte_rdy),
      .frm_err  (frm_err)
   );

   pair_state_t pair_q, pair_nx;
   logic [7:0] hi_byte;
   logic [TW-1:0] to_cnt;
   logic latch_hi, assemble;

   always_comb begin
      pair_nx  = pair_q;
      latch_hi = 1'b0;
      assemble = 1'b0;
      unique case (pair_q)
         WAIT_HI: if (byte_rdy) begin
            latch_hi = 1'b1;
            pair_nx  = WAIT_LO;
         end
         WAIT_LO: if (byte_rdy) begin
            assemble = 1'b1;
            pair_nx  = WAIT_HI;
         end else if (frm_err || to_cnt == TO_END) begin
            pair_nx = WAIT_HI;
         end
         default: pair_nx = WAIT_HI;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pair_q  <= WAIT_HI;
         hi_byte <= '0;
         to_cnt  <= '0;
         cmd     <= '0;
         cmd_rdy <= 1'b0;
      end else begin
         pair_q <= pair_nx;
         if (latch_hi) begin
            hi_byte <= rx_byte;
            to_cnt  <= '0;
         end else if (pair_q == WAIT_LO) begin
            to_cnt <= to_cnt + TW'(1);
         end
         if (assemble) begin
            cmd     <= {hi_byte, rx_byte};
            cmd_rdy <= 1'b1;
         end else if (clr_cmd_rdy) begin
            cmd_rdy <= 1'b0;
         end
      end
   end

   tx_state_t tx_q, tx_nx;
   logic [8:0] tx_sh;
   logic [3:0] bit_idx;
   logic [BW-1:0] tx_cnt;
   logic load, bit_end, frame_end;

   always_comb begin
      tx_nx     = tx_q;
      load      = 1'b0;
      bit_end   = 1'b0;
      frame_end = 1'b0;
      unique case (tx_q)
         TX_IDLE: if (send_resp) begin
            load  = 1'b1;
            tx_nx = TX_XMIT;
         end
         TX_XMIT: begin
            bit_end   = (tx_cnt == BIT_END);
            frame_end = bit_end && (bit_idx == 4'd9);
            // the last stop-bit cycle may chain straight into a new frame
            if (frame_end) begin
               load  = send_resp;
               tx_nx = send_resp ? TX_XMIT : TX_IDLE;
            end
         end
         default: tx_nx = TX_IDLE;
      endcase
   end

   assign tx_busy   = (tx_q == TX_XMIT);
   assign resp_sent = frame_end;

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_q    <= TX_IDLE;
         TX      <= 1'b1;
         tx_sh   <= '1;
         bit_idx <= '0;
         tx_cnt  <= '0;
      end else begin
         tx_q <= tx_nx;
         if (load) begin
            tx_sh   <= {1'b1, resp};
            TX      <= 1'b0;
            bit_idx <= '0;
            tx_cnt  <= '0;
         end else if (frame_end) begin
            TX <= 1'b1;
         end else if (tx_q == TX_XMIT) begin
            if (bit_end) begin
               tx_cnt  <= '0;
               bit_idx <= bit_idx + 4'd1;
               TX      <= tx_sh[0];
               tx_sh   <= {1'b1, tx_sh[8:1]};
            end else begin
               tx_cnt <= tx_cnt + BW'(1);
            end
         end
      end
   end

endmodule
